// File: rtl/tlb_lookup_ctrl_pkg.sv
// Shared widths, field positions and FSM encoding for the TLB lookup controller.
package tlb_lookup_ctrl_pkg;

  localparam int TLB_NUM_SETS       = 16;
  localparam int TLB_NUM_WAYS       = 4;
  localparam int TLB_SET_INDEX_BITS = 4;
  localparam int TLB_LRU_BITS       = 4;

  localparam int VADDR_W       = 32;
  localparam int PADDR_W       = 32;
  localparam int PAGE_OFFSET_W = 12;
  localparam int VPN_W         = 20;
  localparam int PPN_W         = 20;
  localparam int PERMS_W       = 2;
  localparam int WAY_W         = 2;

  // Permission bit positions inside a perms field.
  localparam int PERM_BIT_R = 0;
  localparam int PERM_BIT_W = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WALK_REQ  = 3'd2,
    S_WALK_WAIT = 3'd3,
    S_REFILL    = 3'd4,
    S_RESP      = 3'd5
  } tlb_state_e;

  // A load needs R, a store needs W; returns 1 when the access is not allowed.
  function automatic logic perm_fault(input logic [PERMS_W-1:0] perms,
                                      input logic               is_write);
    return is_write ? ~perms[PERM_BIT_W] : ~perms[PERM_BIT_R];
  endfunction

endpackage

// File: rtl/tlb_lookup_ctrl_if.sv
// Core-side request/response channel of the TLB lookup controller.
interface tlb_lookup_ctrl_if;
  import tlb_lookup_ctrl_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [VADDR_W-1:0] req_vaddr;
  logic               req_is_write;
  logic               resp_valid;
  logic               resp_ready;
  logic [PADDR_W-1:0] resp_paddr;
  logic               resp_fault;

  // Core side: issues requests, consumes responses.
  modport master (
    output req_valid, req_vaddr, req_is_write, resp_ready,
    input  req_ready, resp_valid, resp_paddr, resp_fault
  );

  // Controller side.
  modport slave (
    input  req_valid, req_vaddr, req_is_write, resp_ready,
    output req_ready, resp_valid, resp_paddr, resp_fault
  );

endinterface

// File: rtl/tlb_victim_sel.sv
// Refill victim choice: lowest invalid way, else lowest way holding the minimum LRU count.
module tlb_victim_sel
  import tlb_lookup_ctrl_pkg::*;
#(
  parameter int NUM_WAYS = TLB_NUM_WAYS,
  parameter int LRU_BITS = TLB_LRU_BITS
) (
  input  logic                valid_i     [0:NUM_WAYS-1],
  input  logic [LRU_BITS-1:0] lru_count_i [0:NUM_WAYS-1],
  output logic [WAY_W-1:0]    way_o
);

  logic                found_inv;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    min_way;
  logic [LRU_BITS-1:0] min_cnt;

  // Ascending scan with strict compare keeps ties on the lowest index.
  always_comb begin
    found_inv = 1'b0;
    inv_way   = '0;
    min_way   = '0;
    min_cnt   = lru_count_i[0];
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!valid_i[w] && !found_inv) begin
        found_inv = 1'b1;
        inv_way   = WAY_W'(w);
      end
      if (lru_count_i[w] < min_cnt) begin
        min_cnt = lru_count_i[w];
        min_way = WAY_W'(w);
      end
    end
    way_o = found_inv ? inv_way : min_way;
  end

endmodule

// File: rtl/tlb_lookup_ctrl.sv
// Translation-side TLB controller: set-associative lookup, LRU bump on hit,
// page walk and victim refill on miss, permission check on the response.
module tlb_lookup_ctrl
  import tlb_lookup_ctrl_pkg::*;
#(
  parameter int NUM_SETS       = TLB_NUM_SETS,
  parameter int NUM_WAYS       = TLB_NUM_WAYS,
  parameter int SET_INDEX_BITS = TLB_SET_INDEX_BITS,
  parameter int LRU_BITS       = TLB_LRU_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  tlb_lookup_ctrl_if.slave          bus,
  // storage read port
  output logic [SET_INDEX_BITS-1:0] rd_set_index,
  input  logic                      rd_valid     [0:NUM_WAYS-1],
  input  logic [VPN_W-1:0]          rd_vpn       [0:NUM_WAYS-1],
  input  logic [PPN_W-1:0]          rd_ppn       [0:NUM_WAYS-1],
  input  logic [PERMS_W-1:0]        rd_perms     [0:NUM_WAYS-1],
  input  logic [LRU_BITS-1:0]       rd_lru_count [0:NUM_WAYS-1],
  // storage write port
  output logic                      wr_en,
  output logic                      update_en,
  output logic [SET_INDEX_BITS-1:0] wr_set_index,
  output logic [WAY_W-1:0]          wr_way,
  output logic                      wr_valid,
  output logic [VPN_W-1:0]          wr_vpn,
  output logic [PPN_W-1:0]          wr_ppn,
  output logic [PERMS_W-1:0]        wr_perms,
  output logic [LRU_BITS-1:0]       wr_lru_count,
  // hit LRU bump
  output logic                      lru_update_en,
  output logic [SET_INDEX_BITS-1:0] lru_set_index,
  output logic [WAY_W-1:0]          lru_way,
  // page-table walker
  output logic                      walk_req_valid,
  input  logic                      walk_req_ready,
  output logic [VPN_W-1:0]          walk_req_vpn,
  input  logic                      walk_resp_valid,
  input  logic [PPN_W-1:0]          walk_resp_ppn,
  input  logic [PERMS_W-1:0]        walk_resp_perms,
  input  logic                      walk_resp_fault
);

  localparam logic [SET_INDEX_BITS-1:0] SET_MASK = SET_INDEX_BITS'(NUM_SETS - 1);

  tlb_state_e                state_q;
  logic [VADDR_W-1:0]        vaddr_q;
  logic                      is_write_q;
  logic [SET_INDEX_BITS-1:0] rd_set_index_q;
  logic                      resp_valid_q;
  logic [PADDR_W-1:0]        resp_paddr_q;
  logic                      resp_fault_q;
  logic                      wr_en_q;
  logic                      update_en_q;
  logic [SET_INDEX_BITS-1:0] wr_set_index_q;
  logic [WAY_W-1:0]          wr_way_q;
  logic                      wr_valid_q;
  logic [VPN_W-1:0]          wr_vpn_q;
  logic [PPN_W-1:0]          wr_ppn_q;
  logic [PERMS_W-1:0]        wr_perms_q;
  logic [LRU_BITS-1:0]       wr_lru_count_q;
  logic                      lru_update_en_q;
  logic [SET_INDEX_BITS-1:0] lru_set_index_q;
  logic [WAY_W-1:0]          lru_way_q;
  logic                      walk_req_valid_q;
  logic [VPN_W-1:0]          walk_req_vpn_q;

  logic [VPN_W-1:0]          vpn_q;
  logic [VPN_W-1:0]          req_vpn;
  logic                      hit_d;
  logic [WAY_W-1:0]          hit_way_d;
  logic [PPN_W-1:0]          hit_ppn_d;
  logic [PERMS_W-1:0]        hit_perms_d;
  logic                      lookup_fault_d;
  logic                      refill_fault_d;
  logic [WAY_W-1:0]          victim_way;

  assign vpn_q   = vaddr_q[VADDR_W-1:PAGE_OFFSET_W];
  assign req_vpn = bus.req_vaddr[VADDR_W-1:PAGE_OFFSET_W];

  // Tag match across the set; descending scan so the lowest matching way wins.
  always_comb begin
    hit_d       = 1'b0;
    hit_way_d   = '0;
    hit_ppn_d   = '0;
    hit_perms_d = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (rd_valid[w] && (rd_vpn[w] == vpn_q)) begin
        hit_d       = 1'b1;
        hit_way_d   = WAY_W'(w);
        hit_ppn_d   = rd_ppn[w];
        hit_perms_d = rd_perms[w];
      end
    end
    lookup_fault_d = perm_fault(hit_perms_d, is_write_q);
    refill_fault_d = perm_fault(wr_perms_q, is_write_q);
  end

  tlb_victim_sel #(
    .NUM_WAYS (NUM_WAYS),
    .LRU_BITS (LRU_BITS)
  ) u_victim_sel (
    .valid_i     (rd_valid),
    .lru_count_i (rd_lru_count),
    .way_o       (victim_way)
  );

  // Control FSM with all outputs registered; storage strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      vaddr_q          <= '0;
      is_write_q       <= 1'b0;
      rd_set_index_q   <= '0;
      resp_valid_q     <= 1'b0;
      resp_paddr_q     <= '0;
      resp_fault_q     <= 1'b0;
      wr_en_q          <= 1'b0;
      update_en_q      <= 1'b0;
      wr_set_index_q   <= '0;
      wr_way_q         <= '0;
      wr_valid_q       <= 1'b0;
      wr_vpn_q         <= '0;
      wr_ppn_q         <= '0;
      wr_perms_q       <= '0;
      wr_lru_count_q   <= '0;
      lru_update_en_q  <= 1'b0;
      lru_set_index_q  <= '0;
      lru_way_q        <= '0;
      walk_req_valid_q <= 1'b0;
      walk_req_vpn_q   <= '0;
    end else begin
      wr_en_q         <= 1'b0;
      update_en_q     <= 1'b0;
      lru_update_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            vaddr_q        <= bus.req_vaddr;
            is_write_q     <= bus.req_is_write;
            rd_set_index_q <= req_vpn[SET_INDEX_BITS-1:0] & SET_MASK;
            state_q        <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_d) begin
            resp_valid_q <= 1'b1;
            resp_fault_q <= lookup_fault_d;
            resp_paddr_q <= lookup_fault_d ? '0 : {hit_ppn_d, vaddr_q[PAGE_OFFSET_W-1:0]};
            if (!lookup_fault_d) begin
              lru_update_en_q <= 1'b1;
              lru_set_index_q <= rd_set_index_q;
              lru_way_q       <= hit_way_d;
            end
            state_q <= S_RESP;
          end else begin
            walk_req_valid_q <= 1'b1;
            walk_req_vpn_q   <= vpn_q;
            state_q          <= S_WALK_REQ;
          end
        end
        S_WALK_REQ: begin
          if (walk_req_ready) begin
            walk_req_valid_q <= 1'b0;
            state_q          <= S_WALK_WAIT;
          end
        end
        S_WALK_WAIT: begin
          if (walk_resp_valid) begin
            if (walk_resp_fault) begin
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
              resp_paddr_q <= '0;
              state_q      <= S_RESP;
            end else begin
              wr_en_q        <= 1'b1;
              update_en_q    <= 1'b1;
              wr_valid_q     <= 1'b1;
              wr_set_index_q <= rd_set_index_q;
              wr_way_q       <= victim_way;
              wr_vpn_q       <= vpn_q;
              wr_ppn_q       <= walk_resp_ppn;
              wr_perms_q     <= walk_resp_perms;
              wr_lru_count_q <= '0;
              state_q        <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          resp_valid_q <= 1'b1;
          resp_fault_q <= refill_fault_d;
          resp_paddr_q <= refill_fault_d ? '0 : {wr_ppn_q, vaddr_q[PAGE_OFFSET_W-1:0]};
          state_q      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_paddr = resp_paddr_q;
  assign bus.resp_fault = resp_fault_q;

  assign rd_set_index   = rd_set_index_q;
  assign wr_en          = wr_en_q;
  assign update_en      = update_en_q;
  assign wr_set_index   = wr_set_index_q;
  assign wr_way         = wr_way_q;
  assign wr_valid       = wr_valid_q;
  assign wr_vpn         = wr_vpn_q;
  assign wr_ppn         = wr_ppn_q;
  assign wr_perms       = wr_perms_q;
  assign wr_lru_count   = wr_lru_count_q;
  assign lru_update_en  = lru_update_en_q;
  assign lru_set_index  = lru_set_index_q;
  assign lru_way        = lru_way_q;
  assign walk_req_valid = walk_req_valid_q;
  assign walk_req_vpn   = walk_req_vpn_q;

endmodule

// File: tb/tb_tlb_lookup_ctrl.sv
// Scoreboard bench for tlb_lookup_ctrl with a behavioural tlb_storage model and walker.
module tb_tlb_lookup_ctrl;
  import tlb_lookup_ctrl_pkg::*;

  logic clk;
  logic rst_n;

  tlb_lookup_ctrl_if bus();

  logic [3:0]  rd_set_index;
  logic        rd_valid     [0:3];
  logic [19:0] rd_vpn       [0:3];
  logic [19:0] rd_ppn       [0:3];
  logic [1:0]  rd_perms     [0:3];
  logic [3:0]  rd_lru_count [0:3];
  logic        wr_en, update_en, wr_valid;
  logic [3:0]  wr_set_index, wr_lru_count;
  logic [1:0]  wr_way, wr_perms;
  logic [19:0] wr_vpn, wr_ppn;
  logic        lru_update_en;
  logic [3:0]  lru_set_index;
  logic [1:0]  lru_way;
  logic        walk_req_valid, walk_req_ready;
  logic [19:0] walk_req_vpn;
  logic        walk_resp_valid, walk_resp_fault;
  logic [19:0] walk_resp_ppn;
  logic [1:0]  walk_resp_perms;

  tlb_lookup_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .rd_set_index    (rd_set_index),
    .rd_valid        (rd_valid),
    .rd_vpn          (rd_vpn),
    .rd_ppn          (rd_ppn),
    .rd_perms        (rd_perms),
    .rd_lru_count    (rd_lru_count),
    .wr_en           (wr_en),
    .update_en       (update_en),
    .wr_set_index    (wr_set_index),
    .wr_way          (wr_way),
    .wr_valid        (wr_valid),
    .wr_vpn          (wr_vpn),
    .wr_ppn          (wr_ppn),
    .wr_perms        (wr_perms),
    .wr_lru_count    (wr_lru_count),
    .lru_update_en   (lru_update_en),
    .lru_set_index   (lru_set_index),
    .lru_way         (lru_way),
    .walk_req_valid  (walk_req_valid),
    .walk_req_ready  (walk_req_ready),
    .walk_req_vpn    (walk_req_vpn),
    .walk_resp_valid (walk_resp_valid),
    .walk_resp_ppn   (walk_resp_ppn),
    .walk_resp_perms (walk_resp_perms),
    .walk_resp_fault (walk_resp_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- storage model ----------------
  logic        st_valid [0:15][0:3];
  logic [19:0] st_vpn   [0:15][0:3];
  logic [19:0] st_ppn   [0:15][0:3];
  logic [1:0]  st_perms [0:15][0:3];
  logic [3:0]  st_lru   [0:15][0:3];

  logic        tb_clr, tb_wr;
  logic [3:0]  tb_set, tb_lru;
  logic [1:0]  tb_way, tb_perms;
  logic [19:0] tb_vpn, tb_ppn;

  always @(posedge clk) begin
    if (tb_clr) begin
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) begin
          st_valid[s][w] <= 1'b0;
          st_vpn[s][w]   <= '0;
          st_ppn[s][w]   <= '0;
          st_perms[s][w] <= '0;
          st_lru[s][w]   <= '0;
        end
    end else if (tb_wr) begin
      st_valid[tb_set][tb_way] <= 1'b1;
      st_vpn[tb_set][tb_way]   <= tb_vpn;
      st_ppn[tb_set][tb_way]   <= tb_ppn;
      st_perms[tb_set][tb_way] <= tb_perms;
      st_lru[tb_set][tb_way]   <= tb_lru;
    end else begin
      if (wr_en) begin
        st_valid[wr_set_index][wr_way] <= wr_valid;
        st_vpn[wr_set_index][wr_way]   <= wr_vpn;
        st_ppn[wr_set_index][wr_way]   <= wr_ppn;
        st_perms[wr_set_index][wr_way] <= wr_perms;
        st_lru[wr_set_index][wr_way]   <= wr_lru_count;
      end
      if (lru_update_en)
        st_lru[lru_set_index][lru_way] <= st_lru[lru_set_index][lru_way] + 4'd1;
    end
  end

  always_comb begin
    for (int w = 0; w < 4; w++) begin
      rd_valid[w]     = st_valid[rd_set_index][w];
      rd_vpn[w]       = st_vpn[rd_set_index][w];
      rd_ppn[w]       = st_ppn[rd_set_index][w];
      rd_perms[w]     = st_perms[rd_set_index][w];
      rd_lru_count[w] = st_lru[rd_set_index][w];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed { logic [31:0] paddr; logic fault; } resp_t;
  typedef struct packed { logic [3:0] set; logic [1:0] way; logic [19:0] vpn; logic [19:0] ppn; logic [1:0] perms; } wr_t;
  typedef struct packed { logic [3:0] set; logic [1:0] way; } lru_t;

  resp_t       resp_q[$];
  wr_t         wr_q[$];
  lru_t        lru_q[$];
  logic [19:0] walk_q[$];

  int errors = 0;
  int checks = 0;
  int resp_cnt = 0;
  int wr_cnt = 0;
  int lru_cnt = 0;
  int walk_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event with empty expectation queue (t=%0t)", name, $time);
  endtask

  // Monitors sample mid-cycle; the DUT acts on the following rising edge.
  initial begin
    resp_t r; wr_t e; lru_t l; logic [19:0] v;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.resp_valid && bus.resp_ready) begin
          resp_cnt++;
          if (resp_q.size() == 0) unexpected("resp");
          else begin
            r = resp_q.pop_front();
            chk("resp_paddr", bus.resp_paddr, r.paddr);
            chk("resp_fault", 32'(bus.resp_fault), 32'(r.fault));
          end
        end
        if (wr_en) begin
          wr_cnt++;
          chk("update_en", 32'(update_en), 32'd1);
          chk("wr_valid", 32'(wr_valid), 32'd1);
          chk("wr_lru_count", 32'(wr_lru_count), 32'd0);
          if (wr_q.size() == 0) unexpected("wr_en");
          else begin
            e = wr_q.pop_front();
            chk("wr_set_index", 32'(wr_set_index), 32'(e.set));
            chk("wr_way", 32'(wr_way), 32'(e.way));
            chk("wr_vpn", 32'(wr_vpn), 32'(e.vpn));
            chk("wr_ppn", 32'(wr_ppn), 32'(e.ppn));
            chk("wr_perms", 32'(wr_perms), 32'(e.perms));
          end
        end
        if (wr_en || update_en || lru_update_en)
          chk("strobe_exclusive", 32'((wr_en | update_en) & lru_update_en), 32'd0);
        if (lru_update_en) begin
          lru_cnt++;
          if (lru_q.size() == 0) unexpected("lru_update_en");
          else begin
            l = lru_q.pop_front();
            chk("lru_set_index", 32'(lru_set_index), 32'(l.set));
            chk("lru_way", 32'(lru_way), 32'(l.way));
          end
        end
        if (walk_req_valid && walk_req_ready) begin
          walk_cnt++;
          if (walk_q.size() == 0) unexpected("walk_req");
          else begin
            v = walk_q.pop_front();
            chk("walk_req_vpn", 32'(walk_req_vpn), 32'(v));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] va, input logic w);
    int n = 0;
    while (!bus.req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!bus.req_ready) unexpected("req_ready_timeout");
    bus.req_valid    = 1'b1;
    bus.req_vaddr    = va;
    bus.req_is_write = w;
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
  endtask

  task automatic walker_accept();
    int n = 0;
    while (!walk_req_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("walk_req_seen", 32'(walk_req_valid), 32'd1);
    walk_req_ready = 1'b1;
    @(posedge clk); #1;
    walk_req_ready = 1'b0;
  endtask

  task automatic walker_respond(input logic [19:0] ppn, input logic [1:0] perms, input logic flt);
    repeat (2) @(posedge clk);
    #1;
    walk_resp_valid = 1'b1;
    walk_resp_ppn   = ppn;
    walk_resp_perms = perms;
    walk_resp_fault = flt;
    @(posedge clk); #1;
    walk_resp_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (resp_cnt < target && n < 100) begin @(posedge clk); #1; n++; end
    chk("resp_count", 32'(resp_cnt), 32'(target));
  endtask

  task automatic preload(input logic [3:0] s, input logic [1:0] w, input logic [19:0] vpn,
                         input logic [19:0] ppn, input logic [1:0] perms, input logic [3:0] lru);
    tb_wr = 1'b1; tb_set = s; tb_way = w; tb_vpn = vpn; tb_ppn = ppn; tb_perms = perms; tb_lru = lru;
    @(posedge clk); #1;
    tb_wr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_resp_paddr"}, bus.resp_paddr, 32'd0);
    chk({tag, "_resp_fault"}, 32'(bus.resp_fault), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, "_update_en"}, 32'(update_en), 32'd0);
    chk({tag, "_lru_update_en"}, 32'(lru_update_en), 32'd0);
    chk({tag, "_walk_req_valid"}, 32'(walk_req_valid), 32'd0);
    chk({tag, "_walk_req_vpn"}, 32'(walk_req_vpn), 32'd0);
    chk({tag, "_rd_set_index"}, 32'(rd_set_index), 32'd0);
    chk({tag, "_wr_vpn"}, 32'(wr_vpn), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int wr_before, walk_before, lru_before;
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_is_write = 1'b0; bus.resp_ready = 1'b1;
    walk_req_ready = 1'b0; walk_resp_valid = 1'b0; walk_resp_ppn = '0;
    walk_resp_perms = '0; walk_resp_fault = 1'b0;
    tb_clr = 1'b1; tb_wr = 1'b0; tb_set = '0; tb_way = '0; tb_vpn = '0; tb_ppn = '0;
    tb_perms = '0; tb_lru = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1; tb_clr = 1'b0;
    @(posedge clk); #1;

    // Cold miss on set 5, refill into way 0.
    walk_q.push_back(20'h00005);
    wr_q.push_back('{set: 4'd5, way: 2'd0, vpn: 20'h00005, ppn: 20'h12345, perms: 2'b11});
    resp_q.push_back('{paddr: 32'h1234_5123, fault: 1'b0});
    issue(32'h0000_5123, 1'b0);
    chk("miss_walk_early", 32'(walk_req_valid), 32'd0);
    @(posedge clk); #1;
    chk("miss_walk_at_n2", 32'(walk_req_valid), 32'd1);
    walker_accept();
    walker_respond(20'h12345, 2'b11, 1'b0);
    chk("refill_after_walk", 32'(wr_en), 32'd1);
    @(posedge clk); #1;
    chk("resp_after_refill", 32'(bus.resp_valid), 32'd1);
    wait_resp(1);

    // Same load now hits: LRU bump, response at N+2, no walk.
    walk_before = walk_cnt;
    lru_q.push_back('{set: 4'd5, way: 2'd0});
    resp_q.push_back('{paddr: 32'h1234_5123, fault: 1'b0});
    issue(32'h0000_5123, 1'b0);
    chk("hit_resp_early", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
    chk("hit_resp_at_n2", 32'(bus.resp_valid), 32'd1);
    chk("hit_lru_at_n2", 32'(lru_update_en), 32'd1);
    wait_resp(2);
    chk("hit_no_walk", 32'(walk_cnt), 32'(walk_before));

    // Store to a read-only page: refill still happens, response faults.
    walk_q.push_back(20'h00007);
    wr_q.push_back('{set: 4'd7, way: 2'd0, vpn: 20'h00007, ppn: 20'h0BEEF, perms: 2'b01});
    resp_q.push_back('{paddr: 32'h0, fault: 1'b1});
    issue(32'h0000_7ABC, 1'b1);
    walker_accept();
    walker_respond(20'h0BEEF, 2'b01, 1'b0);
    wait_resp(3);

    // Full set 3 with LRU counts 3,1,1,2; way 0 is read-only.
    preload(4'd3, 2'd0, 20'h10003, 20'h11111, 2'b01, 4'd3);
    preload(4'd3, 2'd1, 20'h20003, 20'h22222, 2'b11, 4'd1);
    preload(4'd3, 2'd2, 20'h30003, 20'h33333, 2'b11, 4'd1);
    preload(4'd3, 2'd3, 20'h40003, 20'h44444, 2'b11, 4'd2);

    // Hit with permission fault: no LRU bump.
    lru_before = lru_cnt;
    resp_q.push_back('{paddr: 32'h0, fault: 1'b1});
    issue(32'h1000_3000, 1'b1);
    @(posedge clk); #1;
    chk("hitfault_no_lru", 32'(lru_update_en), 32'd0);
    wait_resp(4);
    chk("hitfault_lru_cnt", 32'(lru_cnt), 32'(lru_before));

    // Hit on way 3 at the top of the page.
    lru_q.push_back('{set: 4'd3, way: 2'd3});
    resp_q.push_back('{paddr: 32'h4444_4FFF, fault: 1'b0});
    issue(32'h4000_3FFF, 1'b0);
    wait_resp(5);

    // Miss on full set 3: victim is way 1 (minimum count, lowest index on tie).
    walk_q.push_back(20'h50003);
    wr_q.push_back('{set: 4'd3, way: 2'd1, vpn: 20'h50003, ppn: 20'h0ABCD, perms: 2'b01});
    resp_q.push_back('{paddr: 32'h0ABC_D004, fault: 1'b0});
    issue(32'h5000_3004, 1'b0);
    walker_accept();
    walker_respond(20'h0ABCD, 2'b01, 1'b0);
    wait_resp(6);

    // Walk fault: no storage write, faulting response.
    wr_before = wr_cnt;
    walk_q.push_back(20'h00009);
    resp_q.push_back('{paddr: 32'h0, fault: 1'b1});
    issue(32'h0000_9000, 1'b0);
    walker_accept();
    walker_respond(20'h0F00D, 2'b11, 1'b1);
    wait_resp(7);
    chk("walkfault_no_write", 32'(wr_cnt), 32'(wr_before));

    // Reset while waiting for the walker; the late walk response must be ignored.
    wr_before = wr_cnt;
    walk_q.push_back(20'h0000A);
    issue(32'h0000_A000, 1'b0);
    walker_accept();
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    walk_resp_valid = 1'b1; walk_resp_ppn = 20'h0DEAD; walk_resp_perms = 2'b11; walk_resp_fault = 1'b0;
    @(posedge clk); #1;
    walk_resp_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("postreset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("postreset_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("postreset_no_write", 32'(wr_cnt), 32'(wr_before));

    // Back-pressure: response held stable for 5 cycles, no request accepted.
    bus.resp_ready = 1'b0;
    lru_q.push_back('{set: 4'd5, way: 2'd0});
    resp_q.push_back('{paddr: 32'h1234_5123, fault: 1'b0});
    issue(32'h0000_5123, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_resp_paddr", bus.resp_paddr, 32'h1234_5123);
      chk("hold_resp_fault", 32'(bus.resp_fault), 32'd0);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    wait_resp(8);
    @(posedge clk); #1;
    chk("final_req_ready", 32'(bus.req_ready), 32'd1);

    chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    chk("lru_q_drained", 32'(lru_q.size()), 32'd0);
    chk("walk_q_drained", 32'(walk_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
